id_stage: RTL
=============

Name: id_stage

Overview:
Instruction-decode stage of the ARM-subset 5-stage pipeline. It sits between the IF stage register and the ID/EX pipeline register, and feeds that register directly. It contains:
- the 16x32 register file, written by WB;
- the control unit (opcode/mode to EX command and control bits);
- the condition-check unit.

It produces the `two_src` indication for the hazard unit and squashes control bits on a hazard or a failed condition.

Parameters:
- N, 32, data/PC word width
- REG_COUNT, 16, register-file depth (address width fixed at 4)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- instruction  in  32  fetched instruction from IF stage register
- pc_in  in  N  PC+4 from IF stage register
- hazard  in  1  hazard-unit stall; squashes control bits
- status_reg  in  4  NZCV from status register ({N,Z,C,V} = [3:0])
- wb_en  in  1  writeback enable
- wb_dest  in  4  writeback register index
- wb_value  in  N  writeback data
- pc_out  out  N  = pc_in
- val_rn  out  N  register-file read of Rn
- val_rm  out  N  register-file read of src2
- rd  out  4  instruction[15:12]
- src1  out  4  instruction[19:16]
- src2  out  4  Rd for STR, else instruction[3:0]
- shifter_operand  out  12  instruction[11:0]
- signed_imm  out  24  instruction[23:0]
- imm  out  1  instruction[25]
- exe_cmd  out  4  EX command
- mem_read, mem_write, wb_enable, b, status_update  out  1 each  control bits
- two_src  out  1  instruction reads a second register

Behaviour:
- Fields decoded from `instruction`:
  - cond [31:28], mode [27:26], I [25], opcode [24:21], S [20]
  - Rn [19:16], Rd [15:12], shifter [11:0], imm24 [23:0]
- Register file, R0..R15, N bits each:
  - Reset: asynchronous on rst; Ri <= i.
  - Write: at posedge clk when wb_en; R[wb_dest] <= wb_value. All 16 registers are writable.
  - Read: combinational on both ports, with write-through. If wb_en and wb_dest equals the read index, the port returns wb_value in the same cycle.
  - Reset has priority over a simultaneous write.
- Control unit, mode 00 (arithmetic), opcode -> exe_cmd:

  | Op | opcode | exe_cmd | wb_enable |
  |---|---|---|---|
  | MOV | 1101 | 0001 | 1 |
  | MVN | 1111 | 1001 | 1 |
  | ADD | 0100 | 0010 | 1 |
  | ADC | 0101 | 0011 | 1 |
  | SUB | 0010 | 0100 | 1 |
  | SBC | 0110 | 0101 | 1 |
  | AND | 0000 | 0110 | 1 |
  | ORR | 1100 | 0111 | 1 |
  | EOR | 0001 | 1000 | 1 |
  | CMP | 1010 | 0100 | 0 |
  | TST | 1000 | 0110 | 0 |

  - status_update = S for all mode-00 opcodes.
  - Any other opcode: all control bits 0, exe_cmd 0000.
- Control unit, mode 01 (memory), opcode 0100:
  - S=1 (LDR): mem_read=1, wb_enable=1, exe_cmd=0010.
  - S=0 (STR): mem_write=1, exe_cmd=0010.
- Control unit, mode 10: b=1, exe_cmd=0000.
- Control unit, mode 11: NOP, all control bits 0.
- Condition check (NZCV from status_reg):

  | Code | Name | Passes when |
  |---|---|---|
  | 0000 | EQ | Z |
  | 0001 | NE | !Z |
  | 0010 | CS | C |
  | 0011 | CC | !C |
  | 0100 | MI | N |
  | 0101 | PL | !N |
  | 0110 | VS | V |
  | 0111 | VC | !V |
  | 1000 | HI | C&!Z |
  | 1001 | LS | !C\|Z |
  | 1010 | GE | N==V |
  | 1011 | LT | N!=V |
  | 1100 | GT | !Z&(N==V) |
  | 1101 | LE | Z\|(N!=V) |
  | 1110 | AL | always |
  | 1111 | (none) | never |

- Squash rule: if hazard=1 or the condition fails, then mem_read, mem_write, wb_enable, b, status_update and exe_cmd are all forced to 0. Datapath outputs are unaffected.
- two_src:
  - = (mode==00 & I==0) | (mode==01 & S==0).
  - Computed from raw decode and not squashed, since the hazard unit needs it while stalling.
- Latency and timing:
  - Decode is purely combinational, zero cycles.
  - A register write becomes visible through the bypass in the same cycle, and from storage from the next cycle on.
- Reset mid-operation: register contents revert to index values immediately. Outputs follow combinationally.

Test Plan:
1. Reset, then instruction=0xE2821005 (ADD R1,R2,#5), status_reg=0, hazard=0 -> exe_cmd=0010, wb_enable=1, imm=1, val_rn=2, src1=2, rd=1, shifter_operand=0x005, two_src=0.
2. wb_en=1, wb_dest=3, wb_value=0xDEADBEEF, instruction with Rn=3 -> val_rn=0xDEADBEEF in the same cycle. Next cycle with wb_en=0 -> still 0xDEADBEEF. Then pulse rst -> val_rn=3.
3. MOVEQ R0,#1 (0x03A00001):
   - status_reg=0000 -> all control bits 0, exe_cmd=0.
   - status_reg=0100 (Z=1) -> wb_enable=1, exe_cmd=0001.
4. STR R4,[R5,#8] (0xE4854008) -> mem_write=1, mem_read=0, wb_enable=0, exe_cmd=0010, src2=4, val_rm=4, two_src=1. LDR variant (0xE4954008) -> mem_read=1, wb_enable=1, two_src=0.
5. B with cond AL (0xEAFFFFFE) -> b=1, signed_imm=0xFFFFFE, wb_enable=0. Same instruction with hazard=1 -> b=0.
6. ADD R1,R2,R3 (0xE0821003) with hazard=1 -> all control bits 0, two_src=1, val_rn=2, val_rm=3.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode stage: register file, control unit and condition check.
// Ports:
//   clk, rst        clock, async active-high reset (register file only)
//   instruction     fetched word from the IF stage register
//   pc_in / pc_out  PC+4, passed straight through
//   hazard          stall from the hazard unit, squashes control bits
//   status_reg      NZCV flags, {N,Z,C,V} = [3:0]
//   wb_en/dest/val  writeback port into the register file
//   val_rn, val_rm  register reads of Rn and src2 (write-through)
//   rd, src1, src2  register indices for later stages / hazard unit
//   shifter_operand, signed_imm, imm   immediate fields
//   exe_cmd, mem_read, mem_write, wb_enable, b, status_update  control
//   two_src         instruction reads a second register (never squashed)
module id_stage #(
   parameter int N         = 32,
   parameter int REG_COUNT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  instruction,
   input  logic [N-1:0] pc_in,
   input  logic         hazard,
   input  logic [3:0]   status_reg,
   input  logic         wb_en,
   input  logic [3:0]   wb_dest,
   input  logic [N-1:0] wb_value,
   output logic [N-1:0] pc_out,
   output logic [N-1:0] val_rn,
   output logic [N-1:0] val_rm,
   output logic [3:0]   rd,
   output logic [3:0]   src1,
   output logic [3:0]   src2,
   output logic [11:0]  shifter_operand,
   output logic [23:0]  signed_imm,
   output logic         imm,
   output logic [3:0]   exe_cmd,
   output logic         mem_read,
   output logic         mem_write,
   output logic         wb_enable,
   output logic         b,
   output logic         status_update,
   output logic         two_src
);

   logic [3:0] cond;
   logic [1:0] mode;
   logic [3:0] opcode;
   logic       s_bit;

   assign cond   = instruction[31:28];
   assign mode   = instruction[27:26];
   assign opcode = instruction[24:21];
   assign s_bit  = instruction[20];

   assign pc_out          = pc_in;
   assign imm             = instruction[25];
   assign src1            = instruction[19:16];
   assign rd              = instruction[15:12];
   assign shifter_operand = instruction[11:0];
   assign signed_imm      = instruction[23:0];

   logic m_arith, m_mem, m_br, m_nop;
   assign m_arith = (mode == 2'b00);
   assign m_mem   = (mode == 2'b01);
   assign m_br    = (mode == 2'b10);
   assign m_nop   = (mode == 2'b11);

   // A store reads Rd as its data source, so it goes out on the second port.
   logic is_str;
   assign is_str = m_mem & ~s_bit;
   assign src2   = is_str ? rd : instruction[3:0];

   // Raw decode, so the hazard unit sees it even while we squash.
   assign two_src = (m_arith & ~imm) | is_str;

   // ---------------- register file ----------------
   logic [N-1:0] regs [REG_COUNT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++)
            regs[i] <= N'(i);
      end else if (wb_en) begin
         regs[wb_dest] <= wb_value;
      end
   end

   // Write-through lets WB data reach ID in the same cycle.
   assign val_rn = (wb_en && wb_dest == src1) ? wb_value : regs[src1];
   assign val_rm = (wb_en && wb_dest == src2) ? wb_value : regs[src2];

   // ---------------- control unit ----------------
   logic [3:0] cmd_raw;
   logic       mr_raw, mw_raw, wbe_raw, b_raw, su_raw;

   always_comb begin
      cmd_raw = 4'b0000;
      mr_raw  = 1'b0;
      mw_raw  = 1'b0;
      wbe_raw = 1'b0;
      b_raw   = 1'b0;
      su_raw  = 1'b0;
      unique case (1'b1)
         m_arith: begin
            wbe_raw = 1'b1;
            su_raw  = s_bit;
            case (opcode)
               4'b1101: cmd_raw = 4'b0001;
               4'b1111: cmd_raw = 4'b1001;
               4'b0100: cmd_raw = 4'b0010;
               4'b0101: cmd_raw = 4'b0011;
               4'b0010: cmd_raw = 4'b0100;
               4'b0110: cmd_raw = 4'b0101;
               4'b0000: cmd_raw = 4'b0110;
               4'b1100: cmd_raw = 4'b0111;
               4'b0001: cmd_raw = 4'b1000;
               4'b1010: begin
                  cmd_raw = 4'b0100;
                  wbe_raw = 1'b0;
               end
               4'b1000: begin
                  cmd_raw = 4'b0110;
                  wbe_raw = 1'b0;
               end
               default: begin
                  wbe_raw = 1'b0;
                  su_raw  = 1'b0;
               end
            endcase
         end
         m_mem: begin
            if (opcode == 4'b0100) begin
               cmd_raw = 4'b0010;
               mr_raw  = s_bit;
               wbe_raw = s_bit;
               mw_raw  = ~s_bit;
            end
         end
         m_br: b_raw = 1'b1;
         m_nop: ;
      endcase
   end

   // ---------------- condition check ----------------
   logic fn, fz, fc, fv;
   assign {fn, fz, fc, fv} = status_reg;

   logic cond_ok;
   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         4'b0000: cond_ok = fz;
         4'b0001: cond_ok = ~fz;
         4'b0010: cond_ok = fc;
         4'b0011: cond_ok = ~fc;
         4'b0100: cond_ok = fn;
         4'b0101: cond_ok = ~fn;
         4'b0110: cond_ok = fv;
         4'b0111: cond_ok = ~fv;
         4'b1000: cond_ok = fc & ~fz;
         4'b1001: cond_ok = ~fc | fz;
         4'b1010: cond_ok = (fn == fv);
         4'b1011: cond_ok = (fn != fv);
         4'b1100: cond_ok = ~fz & (fn == fv);
         4'b1101: cond_ok = fz | (fn != fv);
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   logic keep;
   assign keep = cond_ok & ~hazard;

   assign exe_cmd       = keep ? cmd_raw : 4'b0000;
   assign mem_read      = keep & mr_raw;
   assign mem_write     = keep & mw_raw;
   assign wb_enable     = keep & wbe_raw;
   assign b             = keep & b_raw;
   assign status_update = keep & su_raw;

endmodule
